// File: rtl/adc16dv160_capture_ctrl.sv
// Capture sequencer for the ADC16DV160 sample stream: arms on start, aligns to the
// synchronised sync edge, and cuts samples into dsize-word AXI-Stream packets.
module adc16dv160_capture_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DSIZE_W = 24
) (
  input  logic               m00_axis_aclk,
  input  logic               m00_axis_aresetn,
  input  logic               cfg_rt,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [DSIZE_W-1:0] cfg_dsize,
  input  logic               sync,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [DATA_W-1:0]  m00_axis_tdata,
  output logic               m00_axis_tvalid,
  output logic [3:0]         m00_axis_tkeep,
  output logic               m00_axis_tlast,
  input  logic               m00_axis_tready,
  output logic               sts_busy,
  output logic               sts_done,
  output logic               sts_overflow,
  output logic [DSIZE_W-1:0] sts_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]         state;
  logic               sync_meta;
  logic               sync_s;
  logic               sync_d;
  logic               rt;
  logic [DSIZE_W-1:0] dsize;
  logic [DSIZE_W-1:0] cnt;
  logic [DATA_W-1:0]  tdata;
  logic               tvalid;
  logic               tlast;
  logic               done;
  logic               overflow;

  logic sync_rise;
  logic load;
  logic drop;
  logic last_word;

  // Load/drop decisions for the one-deep output register
  always_comb begin
    sync_rise = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    last_word = 1'b0;
    sync_rise = sync_s & ~sync_d;
    last_word = (cnt == (dsize - DSIZE_W'(1)));
    if (state == CAPTURE) begin
      load = s_axis_tvalid & (~tvalid | m00_axis_tready);
      drop = s_axis_tvalid & tvalid & ~m00_axis_tready;
    end else begin
      load = 1'b0;
      drop = 1'b0;
    end
  end

  // Synchroniser, output register, packet counter, sticky flags and sequencer
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state     <= IDLE;
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      sync_d    <= 1'b0;
      rt        <= 1'b0;
      dsize     <= {DSIZE_W{1'b0}};
      cnt       <= {DSIZE_W{1'b0}};
      tdata     <= {DATA_W{1'b0}};
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync_meta <= sync;
      sync_s    <= sync_meta;
      sync_d    <= sync_s;
      if (cfg_abort) begin
        state  <= IDLE;
        tvalid <= 1'b0;
        tlast  <= 1'b0;
        cnt    <= {DSIZE_W{1'b0}};
      end else begin
        if (drop) begin
          overflow <= 1'b1;
        end
        if (load) begin
          tvalid <= 1'b1;
          tdata  <= s_axis_tdata;
          tlast  <= last_word;
          cnt    <= last_word ? {DSIZE_W{1'b0}} : (cnt + DSIZE_W'(1));
        end else if (tvalid && m00_axis_tready) begin
          tvalid <= 1'b0;
          tlast  <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (cfg_start && (cfg_dsize != {DSIZE_W{1'b0}})) begin
              state    <= ARMED;
              rt       <= cfg_rt;
              dsize    <= cfg_dsize;
              done     <= 1'b0;
              overflow <= 1'b0;
              cnt      <= {DSIZE_W{1'b0}};
            end
          end
          ARMED: begin
            if (sync_rise) begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            // RT keeps cutting packets back to back only while sync is still high
            if (load && last_word && (!rt || !sync_s)) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (tvalid && m00_axis_tready && tlast) begin
              state <= rt ? ARMED : IDLE;
              if (!rt) begin
                done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign s_axis_tready   = 1'b1;
  assign m00_axis_tdata  = tdata;
  assign m00_axis_tvalid = tvalid;
  assign m00_axis_tlast  = tlast;
  assign m00_axis_tkeep  = {4{tvalid}};
  assign sts_busy        = (state != IDLE);
  assign sts_done        = done;
  assign sts_overflow    = overflow;
  assign sts_count       = cnt;

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
// Self-checking bench for adc16dv160_capture_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model of the capture rules.
module tb_adc16dv160_capture_ctrl;

  localparam int DATA_W  = 32;
  localparam int DSIZE_W = 24;

  logic               clk = 1'b0;
  logic               rstn;
  logic               cfg_rt;
  logic               cfg_start;
  logic               cfg_abort;
  logic [DSIZE_W-1:0] cfg_dsize;
  logic               sync;
  logic [DATA_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  m_data;
  logic               m_valid;
  logic [3:0]         m_keep;
  logic               m_last;
  logic               m_ready;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [DSIZE_W-1:0] count;

  int checks = 0;
  int errors = 0;

  adc16dv160_capture_ctrl #(.DATA_W(DATA_W), .DSIZE_W(DSIZE_W)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rstn),
    .cfg_rt           (cfg_rt),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_dsize        (cfg_dsize),
    .sync             (sync),
    .s_axis_tdata     (s_data),
    .s_axis_tvalid    (s_valid),
    .s_axis_tready    (s_ready),
    .m00_axis_tdata   (m_data),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tkeep   (m_keep),
    .m00_axis_tlast   (m_last),
    .m00_axis_tready  (m_ready),
    .sts_busy         (busy),
    .sts_done         (done),
    .sts_overflow     (ovf),
    .sts_count        (count)
  );

  always #5 clk = ~clk;

  // Behavioural model: capture phase, the held output word and the status registers
  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_CAP   = 2;
  localparam int PH_DRAIN = 3;

  int                 ph;
  bit                 mv;
  bit                 ml;
  logic [DATA_W-1:0]  md;
  int                 mcnt;
  bit                 mdone;
  bit                 movf;
  bit                 mrt;
  int                 mdsize;
  bit                 pin_hist [3];

  logic [32:0] acc_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit lvl, rise, full, acc, wrap, ld;
    if (!rstn) begin
      ph = PH_IDLE; mv = 0; ml = 0; md = '0; mcnt = 0;
      mdone = 0; movf = 0; mrt = 0; mdsize = 0;
      pin_hist[0] = 0; pin_hist[1] = 0; pin_hist[2] = 0;
      return;
    end
    // sync level seen two clocks late; a rise is that level against the clock before
    lvl  = pin_hist[1];
    rise = pin_hist[1] && !pin_hist[2];
    pin_hist[2] = pin_hist[1];
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = sync;
    if (cfg_abort) begin
      ph = PH_IDLE; mv = 0; ml = 0; mcnt = 0;
      return;
    end
    full = mv;
    acc  = mv && m_ready;
    ld   = (ph == PH_CAP) && s_valid && (!full || m_ready);
    if ((ph == PH_CAP) && s_valid && full && !m_ready) movf = 1;
    wrap = ld && (mcnt + 1 == mdsize);
    if (ph == PH_DRAIN && acc && ml) begin
      ph = mrt ? PH_WAIT : PH_IDLE;
      if (!mrt) mdone = 1;
    end else if (ph == PH_WAIT && rise) begin
      ph = PH_CAP;
    end else if (ph == PH_CAP && wrap && !(mrt && lvl)) begin
      ph = PH_DRAIN;
    end else if (ph == PH_IDLE && cfg_start && cfg_dsize != 0) begin
      ph = PH_WAIT; mrt = cfg_rt; mdsize = int'(cfg_dsize);
      mdone = 0; movf = 0; mcnt = 0;
    end
    if (ld) begin
      mv = 1; md = s_data; ml = wrap;
      mcnt = wrap ? 0 : mcnt + 1;
    end else if (acc) begin
      mv = 0; ml = 0;
    end
  endtask

  task automatic compare();
    chk("tvalid", m_valid, mv);
    chk("tlast", m_last, ml);
    chk("tdata", m_data, md);
    chk("tkeep", m_keep, mv ? 4'hF : 4'h0);
    chk("s_tready", s_ready, 1'b1);
    chk("busy", busy, ph != PH_IDLE);
    chk("done", done, mdone);
    chk("overflow", ovf, movf);
    chk("count", count, mcnt);
  endtask

  task automatic cycle();
    if (rstn && m_valid && m_ready) acc_q.push_back({m_last, m_data});
    @(posedge clk);
    model_step();
    #1;
    compare();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    s_data = s_data + 32'd1;
  endtask

  // Consecutive data inside [first, first+len) and tlast only on the final word
  task automatic chk_pkt(input string nm, input int first, input int len);
    chk({nm, "_size"}, (acc_q.size() >= first + len), 1'b1);
    if (acc_q.size() >= first + len) begin
      for (int i = 0; i < len; i++) begin
        chk({nm, "_last"}, acc_q[first+i][32], (i == len - 1));
        if (i > 0) chk({nm, "_data"}, acc_q[first+i][31:0], acc_q[first+i-1][31:0] + 32'd1);
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] d0;
    rstn = 1'b0; cfg_rt = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_dsize = '0; sync = 1'b0; s_data = 32'h1000; s_valid = 1'b1; m_ready = 1'b1;
    repeat (3) cycle();
    chk("reset_tvalid", m_valid, 1'b0);
    chk("reset_tready", s_ready, 1'b1);
    chk("reset_tdata", m_data, 32'd0);
    rstn = 1'b1;
    cycle();

    // single-shot packet, also pins the sync-to-first-load latency
    acc_q.delete();
    cfg_dsize = 24'd4; cfg_rt = 1'b0; cfg_start = 1'b1;
    cycle();
    sync = 1'b1; d0 = s_data; n = 0;
    while (!m_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("sync_latency", n, 4);
    sync = 1'b0;
    repeat (8) cycle();
    chk("ss_words", acc_q.size(), 4);
    if (acc_q.size() > 0) chk("ss_first", acc_q[0][31:0], d0 + 32'd3);
    chk_pkt("ss", 0, 4);
    chk("ss_done", done, 1'b1);
    chk("ss_busy", busy, 1'b0);
    chk("ss_model_done", mdone, 1'b1);

    // RT: three packets while sync high, then a second sync pulse
    acc_q.delete();
    cfg_rt = 1'b1; cfg_start = 1'b1;
    cycle();
    sync = 1'b1;
    repeat (10) cycle();
    sync = 1'b0;
    repeat (12) cycle();
    chk("rt_words", acc_q.size(), 12);
    chk_pkt("rt_p1", 0, 4);
    chk_pkt("rt_p2", 4, 4);
    chk_pkt("rt_p3", 8, 4);
    chk("rt_armed", busy, 1'b1);
    sync = 1'b1;
    repeat (3) cycle();
    sync = 1'b0;
    repeat (12) cycle();
    chk("rt2_words", acc_q.size(), 16);
    chk_pkt("rt2_p", 12, 4);
    cfg_abort = 1'b1;
    cycle();

    // backpressure: two stalled edges drop two samples
    acc_q.delete();
    cfg_rt = 1'b0; cfg_dsize = 24'd8; cfg_start = 1'b1;
    cycle();
    sync = 1'b1;
    repeat (3) cycle();
    sync = 1'b0;
    repeat (3) cycle();
    m_ready = 1'b0;
    repeat (2) cycle();
    m_ready = 1'b1;
    repeat (10) cycle();
    chk("bp_words", acc_q.size(), 8);
    chk("bp_overflow", ovf, 1'b1);
    chk("bp_done", done, 1'b1);
    if (acc_q.size() == 8) begin
      chk("bp_gap", acc_q[3][31:0], acc_q[2][31:0] + 32'd3);
      chk("bp_span", acc_q[7][31:0], acc_q[0][31:0] + 32'd9);
      chk("bp_last", acc_q[7][32], 1'b1);
      chk("bp_not_last", acc_q[6][32], 1'b0);
    end

    // abort with a held word, then a clean packet
    acc_q.delete();
    cfg_start = 1'b1;
    cycle();
    sync = 1'b1;
    repeat (3) cycle();
    sync = 1'b0;
    repeat (2) cycle();
    m_ready = 1'b0; cfg_abort = 1'b1;
    cycle();
    chk("abort_tvalid", m_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", count, 24'd0);
    m_ready = 1'b1;
    acc_q.delete();
    cfg_start = 1'b1;
    cycle();
    sync = 1'b1;
    repeat (3) cycle();
    sync = 1'b0;
    repeat (15) cycle();
    chk("post_abort_words", acc_q.size(), 8);
    chk_pkt("post_abort", 0, 8);

    // corner cases: zero dsize, sync while idle, start+abort together
    acc_q.delete();
    cfg_dsize = 24'd0; cfg_start = 1'b1;
    cycle();
    chk("dsize0_busy", busy, 1'b0);
    cfg_dsize = 24'd4; sync = 1'b1;
    repeat (3) cycle();
    sync = 1'b0;
    repeat (4) cycle();
    chk("idle_sync_words", acc_q.size(), 0);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    cycle();
    chk("start_abort_busy", busy, 1'b0);

    // sub-clock sync glitch between edges is not seen
    cfg_start = 1'b1;
    cycle();
    #2 sync = 1'b1;
    #2 sync = 1'b0;
    repeat (6) cycle();
    chk("glitch_busy", busy, 1'b1);
    chk("glitch_words", acc_q.size(), 0);
    chk("glitch_tvalid_known", $isunknown(m_valid), 1'b0);
    cfg_abort = 1'b1;
    cycle();

    // reset in the middle of a packet
    cfg_dsize = 24'd8; cfg_start = 1'b1;
    cycle();
    sync = 1'b1;
    repeat (5) cycle();
    m_ready = 1'b0;
    repeat (2) cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1; sync = 1'b0; m_ready = 1'b1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ovf", ovf, 1'b0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s_valid   = ($urandom_range(0, 4) != 0);
      s_data    = $urandom;
      m_ready   = ($urandom_range(0, 3) != 0);
      cfg_start = ($urandom_range(0, 15) == 0);
      cfg_abort = ($urandom_range(0, 199) == 0);
      cfg_rt    = $urandom_range(0, 1);
      cfg_dsize = DSIZE_W'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) sync = ~sync;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
